// File: rtl/lcd_sched_pkg.sv
// Shared types and constants for the LCD write scheduler.
// LCD_SCHED_AUTOWRAP_EN selects line-2 padding and auto-clear.
package lcd_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    ACK,
    PAD,
    CLRWRAP
  } state_t;

  typedef enum logic [1:0] {
    W_CLEAR,
    W_CHAR,
    W_PAD
  } wr_kind_t;

  localparam logic [7:0] CMD_CLEAR      = 8'h01;
  localparam logic [7:0] CHAR_SPACE     = 8'h20;
  localparam int         DDRAM_LINE_LEN = 40;
  localparam logic [7:0] PRINT_LO       = 8'h20;
  localparam logic [7:0] PRINT_HI       = 8'h7E;

  function automatic logic is_printable(
    input logic [7:0] c
  );
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/lcd_sched_fifo.sv
// First-word fall-through character buffer, 8 bits wide.
// Writes when full and reads when empty are ignored.
module lcd_sched_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_wr;
  logic        do_rd;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_data = mem[rptr[AW-1:0]];
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + (AW+1)'(1);
      if (do_rd) rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lcd_write_scheduler.sv
// Arbitrates keypad characters and clears into the lcd_wrapper port.
// Define LCD_SCHED_AUTOWRAP_EN for line-2 padding and auto-clear.
module lcd_write_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int COLS       = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              key_char,
  input  logic                    key_strobe,
  input  logic                    clr_req,
  input  logic                    lcd_ready,
  output logic [7:0]              lcd_data,
  output logic                    lcd_valid,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    cursor_row,
  output logic                    busy,
  output logic                    overflow
);

  localparam int CW = $clog2(COLS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  localparam logic [4:0] PAD_LAST =
    5'(DDRAM_LINE_LEN - COLS - 1);

  state_t     state;
  wr_kind_t   kind;
  logic       clr_pend;
  logic       line_full;
  logic [4:0] pad_cnt;

  logic       push;
  logic       drop;
  logic       pick_chr;
  logic       discard;
  logic       empty;
  logic       full;
  logic [7:0] head;

  assign push     = key_strobe && is_printable(key_char);
  assign drop     = push && full;
  assign pick_chr = (state == IDLE) && !clr_pend &&
                    !empty && !line_full && lcd_ready;
  assign discard  = (state == IDLE) && !clr_pend &&
                    !empty && line_full;
  assign busy     = (state != IDLE) || !empty || clr_pend;

  lcd_sched_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (key_char),
    .rd_en   (pick_chr || discard),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      kind       <= W_CLEAR;
      lcd_data   <= 8'h00;
      lcd_valid  <= 1'b0;
      cursor_col <= '0;
      cursor_row <= 1'b0;
      overflow   <= 1'b0;
      clr_pend   <= 1'b1;
      line_full  <= 1'b0;
      pad_cnt    <= '0;
    end else begin
      lcd_valid <= 1'b0;
      if (clr_req) clr_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (clr_pend && lcd_ready) begin
            lcd_data  <= CMD_CLEAR;
            lcd_valid <= 1'b1;
            kind      <= W_CLEAR;
            clr_pend  <= clr_req;
            state     <= ISSUE;
          end else if (discard) begin
            overflow <= 1'b1;
          end else if (pick_chr) begin
            lcd_data  <= head;
            lcd_valid <= 1'b1;
            kind      <= W_CHAR;
            state     <= ISSUE;
          end
        end
        ISSUE: state <= ACK;
        ACK: begin
          if (!lcd_ready) begin
            unique case (kind)
              W_CLEAR: begin
                cursor_row <= 1'b0;
                cursor_col <= '0;
                overflow   <= 1'b0;
                line_full  <= 1'b0;
                state      <= IDLE;
              end
              W_CHAR: begin
                if (cursor_col == LAST_COL) begin
`ifdef LCD_SCHED_AUTOWRAP_EN
                  if (!cursor_row) begin
                    pad_cnt <= '0;
                    state   <= PAD;
                  end else begin
                    state <= CLRWRAP;
                  end
`else
                  line_full <= 1'b1;
                  state     <= IDLE;
`endif
                end else begin
                  cursor_col <= cursor_col + 1'b1;
                  state      <= IDLE;
                end
              end
              W_PAD: begin
                if (pad_cnt == PAD_LAST) begin
                  cursor_row <= 1'b1;
                  cursor_col <= '0;
                  state      <= IDLE;
                end else begin
                  pad_cnt <= pad_cnt + 5'd1;
                  state   <= PAD;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
        PAD: begin
          if (lcd_ready) begin
            lcd_data  <= CHAR_SPACE;
            lcd_valid <= 1'b1;
            kind      <= W_PAD;
            state     <= ISSUE;
          end
        end
        CLRWRAP: begin
          clr_pend <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // a drop in the same cycle as a clear ack still counts
      if (drop) overflow <= 1'b1;
    end
  end

endmodule
